conv2_mac18: RTL

Layer-2 convolution MAC engine; directly downstream of the layer-2 kernel coefficient streamer. Per window: drives k_ready/k_ind to the streamer; consumes 25 taps of 18 signed 16-bit weight streams against a matching stream of window pixels; accumulates 18 parallel dot products; emits 18 scaled, saturated 16-bit feature values with a one-cycle valid strobe to the pooling stage.

---
 rtl/conv2_mac18_pkg.sv | 16 +
 rtl/conv2_mac18_if.sv | 17 +
 rtl/conv2_mac18_lane.sv | 38 +++
 rtl/conv2_mac18.sv | 63 ++++++
 4 files changed

// File: rtl/conv2_mac18_pkg.sv
// conv2_mac18_pkg: shared constants, FSM state type and 16-bit saturation for the layer-2 MAC engine
// No ports. Optional feature macro used elsewhere in this slice: CONV2_RELU_EN.
package conv2_pkg;
  localparam int NUM_TAP   = 25;
  localparam int SETUP_CYC = 3;
  localparam int FRAC      = 8;
  localparam int ACC_W     = 40;
  localparam int NUM_CH    = 18;
  localparam int DW        = 16;
  localparam int KW        = 6;
  localparam int CNT_W     = $clog2(NUM_TAP);
  typedef enum logic [2:0] {IDLE, SETUP, STREAM, DRAIN, DONE} state_t;
  function automatic logic signed [DW-1:0] sat16(input logic signed [ACC_W-1:0] v);
    return (v > ACC_W'(32767)) ? 16'sh7fff : (v < ACC_W'(-32768)) ? 16'sh8000 : v[DW-1:0];
  endfunction
endpackage

// File: rtl/conv2_mac18_if.sv
// conv2_mac18_if: streamer, window-buffer and pooling-side signals of the layer-2 MAC engine
// slave  (engine): in start, k_sel, k[18], pix; out k_ready, k_ind, pix_req, sum[18], out_valid, busy
// master (environment): the mirror image
interface conv2_mac18_if import conv2_pkg::*;;
  logic                 start;
  logic [KW-1:0]        k_sel;
  logic                 k_ready;
  logic [KW-1:0]        k_ind;
  logic signed [DW-1:0] k [NUM_CH];
  logic                 pix_req;
  logic signed [DW-1:0] pix;
  logic signed [DW-1:0] sum [NUM_CH];
  logic                 out_valid;
  logic                 busy;
  modport slave (input start, k_sel, k, pix, output k_ready, k_ind, pix_req, sum, out_valid, busy);
  modport master (output start, k_sel, k, pix, input k_ready, k_ind, pix_req, sum, out_valid, busy);
endinterface

// File: rtl/conv2_mac18_lane.sv
// conv2_mac_lane: one channel: registered product, 40-bit accumulate, >>>FRAC, saturate, optional ReLU
// Ports: clk_in, rst_n (sync, active-low), clr (zero accumulator), mul_en (capture w*pix),
//        acc_en (add product), ld_out (load result into sum), w/pix (signed 16), sum (signed 16 result)
// Macro CONV2_RELU_EN: negative saturated results are forced to 0.
module conv2_mac_lane import conv2_pkg::*; (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 mul_en,
  input  logic                 acc_en,
  input  logic                 ld_out,
  input  logic signed [DW-1:0] w,
  input  logic signed [DW-1:0] pix,
  output logic signed [DW-1:0] sum
);
  logic signed [2*DW-1:0]  r_prod;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [DW-1:0]    w_sat;
  logic signed [DW-1:0]    w_out;
  assign w_sat = sat16(r_acc >>> FRAC);
`ifdef CONV2_RELU_EN
  assign w_out = w_sat[DW-1] ? '0 : w_sat;
`else
  assign w_out = w_sat;
`endif
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_prod <= '0;
      r_acc  <= '0;
      sum    <= '0;
    end else begin
      if (mul_en) r_prod <= (2*DW)'(w) * (2*DW)'(pix);
      if (clr) r_acc <= '0;
      else if (acc_en) r_acc <= r_acc + ACC_W'(r_prod);
      if (ld_out) sum <= w_out;
    end
  end
endmodule

// File: rtl/conv2_mac18.sv
// conv2_mac18: layer-2 convolution MAC engine, 18 parallel 25-tap dot products per window
// Ports: clk_in, rst_n (sync, active-low), bus (conv2_mac18_if.slave: start/k_sel in,
//        k_ready/k_ind/pix_req to streamer and window buffer, sum[18]/out_valid/busy out)
// Macro CONV2_RELU_EN: fuses ReLU into every lane's output.
module conv2_mac18 import conv2_pkg::*; (
  input  logic         clk_in,
  input  logic         rst_n,
  conv2_mac18_if.slave bus
);
  state_t           r_state, w_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [KW-1:0]    r_k_ind;
  logic             r_kr1, r_kr2;
  logic             w_accept, w_kr, w_ld;
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_k_ind <= '0;
      r_kr1   <= 1'b0;
      r_kr2   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= (w_nxt != r_state) ? '0 : r_cnt + 1'b1;
      if (w_accept) r_k_ind <= bus.k_sel;
      r_kr1   <= w_kr;
      r_kr2   <= r_kr1;
    end
  end
  always_comb begin
    w_nxt    = r_state;
    w_accept = bus.start && (r_state == IDLE || r_state == DONE);
    w_kr     = r_state == STREAM;
    w_ld     = r_state == DRAIN && r_cnt == CNT_W'(2);
    case (r_state)
      IDLE:    w_nxt = w_accept ? SETUP : IDLE;
      SETUP:   w_nxt = (r_cnt == CNT_W'(SETUP_CYC - 1)) ? STREAM : SETUP;
      STREAM:  w_nxt = (r_cnt == CNT_W'(NUM_TAP - 1)) ? DRAIN : STREAM;
      DRAIN:   w_nxt = (r_cnt == CNT_W'(2)) ? DONE : DRAIN;
      DONE:    w_nxt = w_accept ? SETUP : IDLE;
      default: w_nxt = IDLE;
    endcase
  end
  assign bus.k_ready   = w_kr;
  assign bus.pix_req   = w_kr;
  assign bus.k_ind     = r_k_ind;
  assign bus.out_valid = r_state == DONE;
  assign bus.busy      = r_state != IDLE;
  // Product capture lags k_ready by one cycle (streamer data latency), accumulation by two.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    conv2_mac_lane u_lane (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .clr    (w_accept),
      .mul_en (r_kr1),
      .acc_en (r_kr2),
      .ld_out (w_ld),
      .w      (bus.k[g]),
      .pix    (bus.pix),
      .sum    (bus.sum[g])
    );
  end
endmodule
